fpga_status_tx: RTL and testbench

- Read-direction counterpart of the FPGA control-register write block.
- Host writes a one-byte query command to channel i (valid_bus[i] + master_data). The block snapshots channel i's status byte and queues a 2-byte response message in that channel's FIFO.
- The host-side transport drains each channel through the have_msg_bus / len_bus / rdreq_bus / slave_data_bus handshake.
- Sits between the host command demux and the per-channel board status sources.

---
 rtl/fpga_status_tx_pkg.sv | 27 ++
 rtl/fpga_status_chan.sv | 121 ++++++++++++
 rtl/fpga_status_tx.sv | 38 +++
 tb/tb_fpga_status_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_status_tx_pkg.sv
// Shared definitions for the status read-back block: command codes, the error
// byte, channel FSM states and the response byte1 selection.
package fpga_status_tx_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] CMD_SNAP = 8'h00;
  localparam logic [7:0] CMD_CHG  = 8'h01;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SEND1 = 1'b1
  } state_t;

  // Second response byte for a command, from the values seen at the accept edge.
  function automatic logic [7:0] resp_byte1(input logic [7:0] cmd,
                                            input logic [7:0] status,
                                            input logic [7:0] mask);
    case (cmd)
      CMD_SNAP: return status;
      CMD_CHG:  return mask;
      default:  return ERR_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/fpga_status_chan.sv
// One status channel: accept/drop FSM, change-mask tracker and a
// first-word-fall-through response FIFO.
module fpga_status_chan
  import fpga_status_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] master_data,
  input  logic       valid,
  input  logic [7:0] status,
  input  logic       rdreq,
  output logic       have_msg,
  output logic [7:0] slave_data,
  output logic [7:0] len,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t          state_q, state_d;
  logic [7:0]      byte1_q, byte1_d;
  logic [7:0]      prev_q, prev_d;
  logic [7:0]      mask_q, mask_d;
  logic            primed_q, primed_d;
  logic            drop_q, drop_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic            clear_mask;
  logic [7:0]      push_data;

  // Room for both bytes is checked before any same-cycle pop, so a message is never split.
  assign accept = (state_q == ST_IDLE) && valid && (count_q <= CW'(DEPTH - 2));
  assign pop    = rdreq && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      byte1_q  <= '0;
      prev_q   <= '0;
      mask_q   <= '0;
      primed_q <= 1'b0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      byte1_q  <= byte1_d;
      prev_q   <= prev_d;
      mask_q   <= mask_d;
      primed_q <= primed_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SEND1;
      ST_SEND1: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push       = 1'b0;
    push_data  = master_data;
    drop_d     = 1'b0;
    clear_mask = 1'b0;
    byte1_d    = byte1_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          push       = 1'b1;
          byte1_d    = resp_byte1(master_data, status, mask_q);
          clear_mask = (master_data == CMD_CHG);
        end else begin
          drop_d = valid;
        end
      end
      ST_SEND1: begin
        push      = 1'b1;
        push_data = byte1_q;
        drop_d    = valid;
      end
      default: ;
    endcase
  end

  // A change landing in the same cycle as a CHG clear is kept for the next query.
  always_comb begin
    prev_d   = status;
    primed_d = 1'b1;
    mask_d   = (clear_mask ? 8'h00 : mask_q) | (primed_q ? (status ^ prev_q) : 8'h00);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (!push && pop) count_d = count_q - CW'(1);
  end

  assign have_msg   = (count_q != '0);
  assign slave_data = mem_q[rd_ptr_q];
  assign len        = 8'(count_q);
  assign drop       = drop_q;

endmodule

// File: rtl/fpga_status_tx.sv
// Host read-back of per-channel board status: one independent query/response
// channel per status source.
module fpga_status_tx
  import fpga_status_tx_pkg::*;
#(
  parameter int N_CH  = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BYTE_W-1:0]        master_data,
  input  logic [N_CH-1:0]          valid_bus,
  input  logic [N_CH*BYTE_W-1:0]   status_bus,
  input  logic [N_CH-1:0]          rdreq_bus,
  output logic [N_CH-1:0]          have_msg_bus,
  output logic [N_CH*BYTE_W-1:0]   slave_data_bus,
  output logic [N_CH*BYTE_W-1:0]   len_bus,
  output logic [N_CH-1:0]          drop_bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    fpga_status_chan #(
      .DEPTH(DEPTH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .master_data(master_data),
      .valid      (valid_bus[i]),
      .status     (status_bus[i*BYTE_W +: BYTE_W]),
      .rdreq      (rdreq_bus[i]),
      .have_msg   (have_msg_bus[i]),
      .slave_data (slave_data_bus[i*BYTE_W +: BYTE_W]),
      .len        (len_bus[i*BYTE_W +: BYTE_W]),
      .drop       (drop_bus[i])
    );
  end

endmodule

// File: tb/tb_fpga_status_tx.sv
// Directed bench for fpga_status_tx with per-channel expected-byte queues.
module tb_fpga_status_tx;

  localparam int N_CH  = 10;
  localparam int DEPTH = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          master_data = '0;
  logic [N_CH-1:0]     valid_bus = '0;
  logic [N_CH*8-1:0]   status_bus = '0;
  logic [N_CH-1:0]     rdreq_bus = '0;
  logic [N_CH-1:0]     have_msg_bus;
  logic [N_CH*8-1:0]   slave_data_bus;
  logic [N_CH*8-1:0]   len_bus;
  logic [N_CH-1:0]     drop_bus;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [N_CH][$];

  fpga_status_tx #(
    .N_CH (N_CH),
    .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .master_data   (master_data),
    .valid_bus     (valid_bus),
    .status_bus    (status_bus),
    .rdreq_bus     (rdreq_bus),
    .have_msg_bus  (have_msg_bus),
    .slave_data_bus(slave_data_bus),
    .len_bus       (len_bus),
    .drop_bus      (drop_bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    valid_bus = '0;
    rdreq_bus = '0;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < N_CH; c++) sb[c].delete();
  endtask

  // Issue one command, then spend the following cycle idle (SEND1 slot).
  task automatic applyStimulus(input int ch, input logic [7:0] cmd,
                               input logic [7:0] exp_b1, input bit exp_accept);
    int base;
    base = sb[ch].size();
    master_data   = cmd;
    valid_bus[ch] = 1'b1;
    step();
    valid_bus[ch] = 1'b0;
    checkOutput("drop_on_issue", 32'(drop_bus[ch]), 32'(!exp_accept));
    if (exp_accept) begin
      sb[ch].push_back(cmd);
      sb[ch].push_back(exp_b1);
      checkOutput("len_after_byte0", 32'(len_bus[ch*8 +: 8]), base + 1);
      checkOutput("have_msg_after_byte0", 32'(have_msg_bus[ch]), 1);
    end else begin
      checkOutput("len_after_drop", 32'(len_bus[ch*8 +: 8]), base);
    end
    step();
    checkOutput("drop_after", 32'(drop_bus[ch]), 0);
    checkOutput("len_after_msg", 32'(len_bus[ch*8 +: 8]), sb[ch].size());
  endtask

  task automatic popCheck(input int ch);
    checkOutput("head_byte", 32'(slave_data_bus[ch*8 +: 8]), 32'(sb[ch][0]));
    rdreq_bus[ch] = 1'b1;
    step();
    rdreq_bus[ch] = 1'b0;
    void'(sb[ch].pop_front());
  endtask

  task automatic drainCheck(input int ch);
    for (int k = 0; k < 2 * DEPTH && sb[ch].size() != 0; k++) popCheck(ch);
    checkOutput("drained_queue", sb[ch].size(), 0);
    checkOutput("drained_have_msg", 32'(have_msg_bus[ch]), 0);
    checkOutput("drained_len", 32'(len_bus[ch*8 +: 8]), 0);
  endtask

  initial begin
    bit         send1;
    bit         acc;
    bit         issue;
    bit         popped;
    logic [7:0] pend;
    logic [7:0] st;
    logic [7:0] cmd;

    $display("[TB] start");
    doReset();
    checkOutput("reset_have_msg", 32'(have_msg_bus), 0);
    checkOutput("reset_drop", 32'(drop_bus), 0);
    checkOutput("reset_len_ch3", 32'(len_bus[3*8 +: 8]), 0);
    checkOutput("reset_data_ch3", 32'(slave_data_bus[3*8 +: 8]), 0);

    // SNAP on channel 3
    status_bus[3*8 +: 8] = 8'h5A;
    applyStimulus(3, 8'h00, 8'h5A, 1'b1);
    drainCheck(3);
    rdreq_bus[3] = 1'b1;
    step();
    rdreq_bus[3] = 1'b0;
    checkOutput("empty_pop_len", 32'(len_bus[3*8 +: 8]), 0);

    // Change mask on channel 0
    doReset();
    status_bus[0 +: 8] = 8'h00;
    step();
    status_bus[0 +: 8] = 8'h81;
    step();
    status_bus[0 +: 8] = 8'h80;
    step();
    applyStimulus(0, 8'h01, 8'h81, 1'b1);
    status_bus[0 +: 8] = 8'h84;
    applyStimulus(0, 8'h01, 8'h00, 1'b1);
    applyStimulus(0, 8'h01, 8'h04, 1'b1);
    drainCheck(0);

    // Unknown command on channel 9, second valid lands in SEND1
    doReset();
    master_data  = 8'h37;
    valid_bus[9] = 1'b1;
    step();
    sb[9].push_back(8'h37);
    sb[9].push_back(8'hEE);
    master_data = 8'h00;
    step();
    valid_bus[9] = 1'b0;
    checkOutput("send1_drop", 32'(drop_bus[9]), 1);
    checkOutput("send1_len", 32'(len_bus[9*8 +: 8]), 2);
    step();
    checkOutput("send1_drop_end", 32'(drop_bus[9]), 0);
    checkOutput("send1_len_end", 32'(len_bus[9*8 +: 8]), 2);
    drainCheck(9);

    // Fill channel 5 to DEPTH and check the drop boundary
    doReset();
    for (int k = 0; k < 8; k++) begin
      status_bus[5*8 +: 8] = 8'(8'h10 + k);
      applyStimulus(5, 8'h00, 8'(8'h10 + k), 1'b1);
    end
    checkOutput("full_len", 32'(len_bus[5*8 +: 8]), DEPTH);
    applyStimulus(5, 8'h00, 8'h00, 1'b0);

    // Continuous pops with new commands while starting full; wraps pointers repeatedly
    send1 = 1'b0;
    pend  = 8'h00;
    rdreq_bus[5] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      checkOutput("stream_len", 32'(len_bus[5*8 +: 8]), sb[5].size());
      checkOutput("stream_have_msg", 32'(have_msg_bus[5]), 32'(sb[5].size() != 0));
      if (sb[5].size() != 0)
        checkOutput("stream_head", 32'(slave_data_bus[5*8 +: 8]), 32'(sb[5][0]));
      st  = 8'($urandom);
      cmd = (i % 6 == 4) ? 8'h42 : 8'h00;
      status_bus[5*8 +: 8] = st;
      issue = !send1 && (i < 50);
      acc   = issue && (sb[5].size() <= DEPTH - 2);
      master_data  = cmd;
      valid_bus[5] = issue;
      popped = (sb[5].size() != 0);
      step();
      valid_bus[5] = 1'b0;
      if (popped) void'(sb[5].pop_front());
      if (send1) sb[5].push_back(pend);
      send1 = 1'b0;
      if (acc) begin
        sb[5].push_back(cmd);
        pend  = (cmd == 8'h00) ? st : 8'hEE;
        send1 = 1'b1;
      end
      checkOutput("stream_drop", 32'(drop_bus[5]), 32'(issue && !acc));
    end
    rdreq_bus[5] = 1'b0;
    checkOutput("stream_final_len", 32'(len_bus[5*8 +: 8]), 0);

    // Reset between byte0 and byte1
    doReset();
    status_bus[2*8 +: 8] = 8'h3C;
    master_data  = 8'h00;
    valid_bus[2] = 1'b1;
    step();
    valid_bus[2] = 1'b0;
    checkOutput("mid_len_before_rst", 32'(len_bus[2*8 +: 8]), 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_have_msg", 32'(have_msg_bus), 0);
    checkOutput("mid_rst_len", 32'(len_bus), 0);
    checkOutput("mid_rst_drop", 32'(drop_bus), 0);
    step();
    rst = 1'b0;
    applyStimulus(2, 8'h00, 8'h3C, 1'b1);
    drainCheck(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
